// File: rtl/abs_window_acc16.sv
// abs_window_acc16: windowed sum and peak of sample magnitudes, one record per window
// Ports: clk; rst (asynchronous, active-high);
//        in_valid/in_ready/in_data: signed 16-bit sample stream;
//        flush: close a non-empty window early;
//        out_valid/out_ready: result record handshake;
//        out_sum/out_peak/out_count: magnitude sum, peak magnitude and sample count of the window.
module abs_window_acc16 #(
    parameter int WIN   = 8,
    parameter int SUM_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [15:0]      out_peak,
    output logic [8:0]       out_count
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t           state;
    logic [SUM_W-1:0] acc_sum;
    logic [SUM_W-1:0] nxt_sum;
    logic [15:0]      acc_peak;
    logic [15:0]      nxt_peak;
    logic [15:0]      mag;
    logic [8:0]       cnt;
    logic [8:0]       nxt_cnt;
    logic             accept;
    logic             close;

    // SUM_W wide enough for WIN full-scale magnitudes means the sum can never wrap
    if (WIN < 2 || WIN > 256 || SUM_W < 16 + $clog2(WIN)) begin : g_param_check
        $error("abs_window_acc16: WIN must be 2..256 and SUM_W >= 16+clog2(WIN)");
    end

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid & in_ready;
    // 0x8000 wraps back to 0x8000, which is the correct magnitude read as unsigned
    assign mag      = in_data[15] ? ~in_data + 16'd1 : in_data;
    assign nxt_sum  = accept ? acc_sum + SUM_W'(mag) : acc_sum;
    assign nxt_peak = (accept && mag > acc_peak) ? mag : acc_peak;
    assign nxt_cnt  = cnt + 9'(accept);
    // nxt_cnt != 0 covers "window already non-empty or a sample arrives now"
    assign close    = in_ready & ((accept & (cnt == 9'(WIN - 1))) | (flush & (nxt_cnt != 9'd0)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_peak  <= '0;
            out_count <= '0;
            acc_sum   <= '0;
            acc_peak  <= '0;
            cnt       <= '0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                out_valid <= 1'b0;
                state     <= ACCUM;
            end
        end else if (close) begin
            out_sum   <= nxt_sum;
            out_peak  <= nxt_peak;
            out_count <= nxt_cnt;
            out_valid <= 1'b1;
            state     <= HOLD;
            acc_sum   <= '0;
            acc_peak  <= '0;
            cnt       <= '0;
        end else begin
            acc_sum   <= nxt_sum;
            acc_peak  <= nxt_peak;
            cnt       <= nxt_cnt;
        end
    end
endmodule
